crc_engine: RTL and testbench
=============================

# crc_engine

Parametrised CRC generator: computes a CRC of configurable width and polynomial over a framed message of `len` words, accepting `DATA_W` bits per cycle through a valid/ready handshake. It replaces the fixed serial 16-bit, 1-bit-per-clock CRC unit used in the problem-set datapaths. It sits between a byte or bit source (UART receiver, packet parser) and the frame checker or transmitter that consumes `crc`.

## Interface
Parameters:
- `CRC_W`, 16: CRC register width, 8..32.
- `POLY`, 16'h1021: generator polynomial; implicit x^CRC_W term omitted.
- `INIT`, 0: CRC register value loaded at `start`.
- `XOROUT`, 0: value XORed into the result when presented on `crc`.
- `DATA_W`, 1: bits consumed per accepted beat, 1..32, MSB first.
- `LEN_W`, 16: width of the word-count input.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a new frame; sampled every cycle.
- `len`, in, LEN_W: number of `DATA_W`-bit words in the frame; sampled with `start`.
- `data_valid`, in, 1: `data` holds a word.
- `data`, in, DATA_W: message word, MSB processed first.
- `ready`, out, 1: engine accepts a word this cycle.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse, `crc` final.
- `crc`, out, CRC_W: final CRC, held from `done` until the next `start`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready`=0, `busy`=0. On `start`: `acc`<=INIT, `cnt`<=len. Next state is RUN if len!=0, otherwise DONE.
- RUN: `ready`=1, `busy`=1. A beat is `data_valid & ready`.
  - Each beat: `acc`<=crc_next(`acc`, `data`) and `cnt`<=`cnt`-1.
  - On the beat with `cnt`==1, go to DONE.
  - No beat: hold state; gaps of any length are legal.
- DONE, one cycle: `done`=1, `busy`=0, `crc`<=`acc`^XOROUT (registered). Then go to IDLE.
- crc_next per bit, MSB of `data` first: `fb`=`acc[CRC_W-1]`^bit; `acc`=(`acc`<<1)^(fb ? POLY : 0). The `DATA_W` steps are unrolled combinationally in one cycle.
- `start` in RUN aborts the frame: reload as from IDLE. `done` does not pulse for the aborted frame, and `crc` keeps its previous value.
- `start` in DONE: `done` still pulses for the finished frame, and the new frame is loaded in the same cycle.
- `start` together with a beat in RUN: `start` wins and the beat is dropped.
- `len` is ignored except when sampled with `start`. `data` is ignored when `ready`=0.

## Timing
- Reset (`reset_n`=0 at a clock edge): state=IDLE, `ready`=0, `busy`=0, `done`=0, `crc`=0, `acc`=0, `cnt`=0. Applies mid-frame as well and discards the frame.
- Cycle after `start`: `ready`=1 (len>0), or `done`=1 (len=0).
- `done` rises on the cycle after the last beat. Latency from the last beat is 1 cycle.
- Minimum frame duration: len+1 cycles after the `start` cycle with back-to-back beats.
- `ready` is a registered state decode with no combinational path from `data_valid`.
- `crc` changes only in the cycle `done` asserts, or at reset.

## Structure
- Package `crc_pkg` holds:
  - the state encoding (IDLE, RUN, DONE);
  - a `crc_step` function (one bit, used by the unrolled loop);
  - the default `POLY` and `INIT` constants for CRC-16/XMODEM and CRC-16/CCITT-FALSE.
- One sub-module `crc_next`: purely combinational, parametrised by CRC_W, POLY and DATA_W. Maps (`acc`, `data`) to next `acc`. It is reused by the transmitter framer.
- `crc_engine` contains the FSM, the counter, `acc` and the output register.

## Test plan
- **XMODEM, byte-wide.** DATA_W=8, defaults, len=9, ASCII "123456789" back-to-back -> `done` pulses 1 cycle after the 9th beat, `crc`=16'h31C3.
- **XMODEM, serial.** DATA_W=1, len=72, same message serial MSB first -> `crc`=16'h31C3; `busy` high for exactly 72 cycles.
- **CCITT-FALSE.** INIT=16'hFFFF, DATA_W=8, "123456789" with `data_valid` deasserted every other cycle -> `crc`=16'h29B1, `done` 1 cycle after the last beat.
- **Zero length.** `start` with len=0, INIT=16'hFFFF, XOROUT=16'hFFFF -> `ready` never asserts, `done` on the next cycle, `crc`=16'h0000.
- **Abort and restart.** `start` after 4 of 9 bytes, then a full "123456789" frame -> exactly one `done` pulse, `crc`=16'h31C3; the previous `crc` is held through the abort.
- **Reset mid-frame.** `reset_n`=0 for 1 cycle during RUN -> next cycle all outputs 0 and state IDLE; a subsequent normal frame gives correct results.

Source files
------------

// File: rtl/crc_pkg.sv
// CRC engine shared definitions: FSM encoding, one-bit
// CRC step and default CRC-16 constants.
package crc_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] XMODEM_POLY      = 16'h1021;
  localparam logic [15:0] XMODEM_INIT      = 16'h0000;
  localparam logic [15:0] CCITT_FALSE_POLY = 16'h1021;
  localparam logic [15:0] CCITT_FALSE_INIT = 16'hFFFF;

  // One bit of the MSB-first CRC shift, on a w-bit
  // register held in the low bits of a 32-bit word.
  function automatic logic [31:0] crc_step(
    input logic [31:0] acc,
    input logic        din,
    input logic [31:0] poly,
    input int unsigned w
  );
    logic [31:0] mask;
    logic        fb;
    mask = 32'hFFFF_FFFF >> (32 - w);
    fb   = acc[5'(w - 1)] ^ din;
    crc_step = ((acc << 1) ^ (fb ? poly : 32'h0)) & mask;
  endfunction

endpackage

// File: rtl/crc_next.sv
// Combinational CRC update over DATA_W bits, MSB first.
// Ports: acc (current CRC), data (word), acc_next (new CRC).
module crc_next
  import crc_pkg::*;
#(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(XMODEM_POLY),
  parameter int DATA_W = 1
) (
  input  logic [CRC_W-1:0]  acc,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  acc_next
);

  logic [CRC_W-1:0] t;

  always_comb begin
    t = acc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      t = CRC_W'(crc_step(32'(t), data[i],
                          32'(POLY), CRC_W));
    end
    acc_next = t;
  end

endmodule

// File: rtl/crc_engine.sv
// Framed CRC generator, DATA_W bits per accepted beat.
// Ports: clock, reset_n (sync, active low), start/len
// (frame load), data_valid/data/ready (word handshake),
// busy (frame running), done (1-cycle pulse), crc (result).
module crc_engine
  import crc_pkg::*;
#(
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = CRC_W'(XMODEM_POLY),
  parameter logic [CRC_W-1:0] INIT = CRC_W'(XMODEM_INIT),
  parameter logic [CRC_W-1:0] XOROUT = '0,
  parameter int DATA_W = 1,
  parameter int LEN_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc
);

  logic [1:0]       state;
  logic [CRC_W-1:0] acc;
  logic [CRC_W-1:0] acc_nxt;
  logic [LEN_W-1:0] cnt;
  logic             beat;
  logic             last;

  crc_next #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_next (
    .acc      (acc),
    .data     (data),
    .acc_next (acc_nxt)
  );

  assign ready = (state == S_RUN);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);
  assign beat  = data_valid & ready;
  assign last  = (cnt == LEN_W'(1));

  // start overrides everything, including a beat in
  // the same cycle; crc is only written on the way into
  // DONE so it is final for the whole done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      crc   <= '0;
    end else if (start) begin
      acc <= INIT;
      cnt <= len;
      if (len == '0) begin
        state <= S_DONE;
        crc   <= INIT ^ XOROUT;
      end else begin
        state <= S_RUN;
      end
    end else begin
      unique case (state)
        S_RUN: begin
          if (beat) begin
            acc <= acc_nxt;
            cnt <= cnt - LEN_W'(1);
            if (last) begin
              state <= S_DONE;
              crc   <= acc_nxt ^ XOROUT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine: three byte-wide and
// one serial instance checked against a division model.
module tb_crc_engine;

  typedef struct packed {
    logic [15:0] crc;
    logic [31:0] cyc;
  } exp_t;

  localparam logic [47:0] INITS =
    {16'hFFFF, 16'hFFFF, 16'h0000};
  localparam logic [47:0] XORS =
    {16'hFFFF, 16'h0000, 16'h0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start8, start1;
  logic [15:0] len8, len1;
  logic        dv8, dv1;
  logic [7:0]  data8;
  logic        data1;
  logic [3:0]  ready_v, busy_v, done_v;
  logic [15:0] crc_v [4];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        q [4][$];
  logic [15:0] last_exp [4];
  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;

  for (genvar g = 0; g < 3; g++) begin : g8
    crc_engine #(
      .CRC_W  (16),
      .POLY   (16'h1021),
      .INIT   (INITS[g*16 +: 16]),
      .XOROUT (XORS[g*16 +: 16]),
      .DATA_W (8),
      .LEN_W  (16)
    ) u_dut (
      .clock      (clk),
      .reset_n    (reset_n),
      .start      (start8),
      .len        (len8),
      .data_valid (dv8),
      .data       (data8),
      .ready      (ready_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .crc        (crc_v[g])
    );
  end

  crc_engine #(
    .CRC_W  (16),
    .POLY   (16'h1021),
    .INIT   (16'h0000),
    .XOROUT (16'h0000),
    .DATA_W (1),
    .LEN_W  (16)
  ) u_ser (
    .clock      (clk),
    .reset_n    (reset_n),
    .start      (start1),
    .len        (len1),
    .data_valid (dv1),
    .data       (data1),
    .ready      (ready_v[3]),
    .busy       (busy_v[3]),
    .done       (done_v[3]),
    .crc        (crc_v[3])
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, req);
    end
  endtask

  // Remainder of the augmented message divided by the
  // generator; INIT enters as the first 16 message bits.
  function automatic logic [15:0] model(
    input bit bits[$],
    input logic [15:0] init,
    input logic [15:0] xo
  );
    bit m[$];
    logic [16:0] r;
    m = bits;
    for (int i = 0; i < 16; i++) m.push_back(1'b0);
    for (int i = 0; i < 16; i++)
      m[i] = m[i] ^ init[4'(15 - i)];
    r = '0;
    foreach (m[i]) begin
      r = {r[15:0], m[i]};
      if (r[16]) r = r ^ 17'h1_1021;
    end
    return r[15:0] ^ xo;
  endfunction

  function automatic void to_bits(
    input logic [7:0] msg[$], output bit bits[$]);
    bits = {};
    foreach (msg[k])
      for (int b = 7; b >= 0; b--)
        bits.push_back(msg[k][b]);
  endfunction

  task automatic push(input bit ser, input bit bits[$]);
    exp_t e;
    e.cyc = cyc + 1;
    if (ser) begin
      e.crc = model(bits, 16'h0, 16'h0);
      q[3].push_back(e);
    end else begin
      for (int g = 0; g < 3; g++) begin
        e.crc = model(bits, INITS[g*16 +: 16],
                      XORS[g*16 +: 16]);
        q[g].push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_v[3]) busy_cnt++;
      if (done_v[0]) done_cnt++;
      if (ready_v[2]) rdy_cnt++;
      if (reset_n) begin
        for (int g = 0; g < 4; g++) begin
          if (done_v[g]) begin
            if (q[g].size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL spurious_done%0d: got done, required none", g);
            end else begin
              e = q[g].pop_front();
              check($sformatf("crc%0d", g),
                    32'(crc_v[g]), 32'(e.crc));
              check($sformatf("done_cyc%0d", g),
                    cyc, e.cyc);
              last_exp[g] = e.crc;
            end
          end
        end
      end
    end
  endtask

  // Caller is at a negedge. gap: 0 back-to-back,
  // 1 every other cycle, 2 random. abort_at >= 0 stops
  // after that many beats, leaving the frame running.
  task automatic run_frame(input bit ser,
                           input logic [7:0] msg[$],
                           input int gap,
                           input int abort_at);
    bit bits[$];
    int nw;
    int i;
    int guard;
    bit v;
    bit rdy;
    to_bits(msg, bits);
    nw = ser ? bits.size() : msg.size();
    if (ser) begin
      start1 = 1'b1;
      len1 = 16'(nw);
      dv1 = 1'b1;
      data1 = 1'($urandom);
    end else begin
      start8 = 1'b1;
      len8 = 16'(nw);
      dv8 = 1'b1;
      data8 = 8'($urandom);
    end
    if (nw == 0 && abort_at < 0) push(ser, bits);
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    len1 = 16'($urandom);
    len8 = 16'($urandom);
    i = 0;
    guard = 0;
    while (i < nw && (abort_at < 0 || i < abort_at)
           && guard < 4000) begin
      case (gap)
        0: v = 1'b1;
        1: v = (guard % 2) == 0;
        default: v = 1'($urandom);
      endcase
      if (ser) begin
        dv1 = v;
        data1 = v ? bits[i] : 1'($urandom);
        rdy = ready_v[3];
      end else begin
        dv8 = v;
        data8 = v ? msg[i] : 8'($urandom);
        rdy = ready_v[0];
      end
      if (v && rdy) begin
        i++;
        if (i == nw && abort_at < 0) push(ser, bits);
      end
      @(negedge clk);
      guard++;
    end
    dv1 = 1'b0;
    dv8 = 1'b0;
    if (guard >= 4000) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d beats, required %0d",
               i, nw);
    end
  endtask

  task automatic drain();
    int k;
    int n;
    k = 0;
    n = q[0].size() + q[1].size()
      + q[2].size() + q[3].size();
    while (n != 0 && k < 300) begin
      @(negedge clk);
      k++;
      n = q[0].size() + q[1].size()
        + q[2].size() + q[3].size();
    end
    check("drain_pending", n, 0);
    for (int g = 0; g < 4; g++) q[g].delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    dv8 = 1'b0;
    dv1 = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready_v), 0);
    check("rst_busy", 32'(busy_v), 0);
    check("rst_done", 32'(done_v), 0);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rst_crc%0d", g),
            32'(crc_v[g]), 0);
      last_exp[g] = 16'h0;
      q[g].delete();
    end
    reset_n = 1'b1;
  endtask

  logic [7:0] msg[$];
  logic [7:0] empty[$];
  logic [7:0] rm[$];
  int b0, d0, r0;
  int n;
  bit ser;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    len8 = '0;
    len1 = '0;
    dv8 = 1'b0;
    dv1 = 1'b0;
    data8 = '0;
    data1 = 1'b0;
    for (int g = 0; g < 4; g++) last_exp[g] = '0;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
            8'h36, 8'h37, 8'h38, 8'h39};
    empty = {};
    fork
      monitor();
    join_none

    do_reset();

    run_frame(1'b0, msg, 0, -1);
    drain();
    check("xmodem8", 32'(crc_v[0]), 32'h31C3);

    run_frame(1'b0, msg, 1, -1);
    drain();
    check("ccitt_false", 32'(crc_v[1]), 32'h29B1);

    b0 = busy_cnt;
    run_frame(1'b1, msg, 0, -1);
    drain();
    check("xmodem1", 32'(crc_v[3]), 32'h31C3);
    check("busy_cycles", busy_cnt - b0, 72);

    r0 = rdy_cnt;
    run_frame(1'b0, empty, 0, -1);
    drain();
    check("zero_len_crc", 32'(crc_v[2]), 0);
    check("zero_len_ready", rdy_cnt - r0, 0);

    d0 = done_cnt;
    run_frame(1'b0, msg, 0, 4);
    for (int g = 0; g < 3; g++)
      check($sformatf("abort_hold%0d", g),
            32'(crc_v[g]), 32'(last_exp[g]));
    run_frame(1'b0, msg, 0, -1);
    drain();
    check("abort_crc", 32'(crc_v[0]), 32'h31C3);
    check("abort_dones", done_cnt - d0, 1);

    run_frame(1'b0, msg, 0, 3);
    do_reset();
    run_frame(1'b0, msg, 2, -1);
    drain();
    check("post_reset", 32'(crc_v[0]), 32'h31C3);

    for (int it = 0; it < 30; it++) begin
      ser = (it % 4) == 3;
      n = ser ? int'($urandom_range(0, 3))
              : int'($urandom_range(0, 12));
      rm = {};
      for (int k = 0; k < n; k++)
        rm.push_back(8'($urandom));
      if (n > 0 && $urandom_range(0, 3) == 0)
        run_frame(ser, rm, 2,
          int'($urandom_range(0, ser ? 8*n - 1 : n - 1)));
      run_frame(ser, rm, int'($urandom_range(0, 2)), -1);
      if ($urandom_range(0, 2) != 0) drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
